// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, status codes and controller states.
package y86_pkg;

  // Instruction codes the controller decodes
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // Stage status codes
  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  // Controller state encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Instructions whose memory result lands in a register after execute
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the controller performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up on inc, holding once all-ones is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, mispredict, ret and halt handling.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   RUN        | normal flow; resolves mispredict, load-use, ret entry
//   RET_WAIT   | fetch held while the return address propagates
//   HALT       | bad writeback status seen; pipeline frozen until rst
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0] r_state;
  logic [1:0] r_ret_cnt;
  logic [1:0] w_next_state;
  logic [1:0] w_next_ret_cnt;
  logic       w_load_use;
  logic       w_mispredict;
  logic       w_f_stall;
  logic       w_d_stall;
  logic       w_w_stall;
  logic       w_d_bubble;
  logic       w_e_bubble;
  logic       w_m_bubble;
  logic       w_not_halt;

  assign w_load_use = is_mem_load(E_icode) && (E_dstM != R_NONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mispredict = (E_icode == I_JXX) && !e_Cnd;

  // Stall/bubble decode and next-state selection
  always_comb begin
    w_f_stall      = 1'b0;
    w_d_stall      = 1'b0;
    w_w_stall      = 1'b0;
    w_d_bubble     = 1'b0;
    w_e_bubble     = 1'b0;
    w_m_bubble     = 1'b0;
    w_next_state   = r_state;
    w_next_ret_cnt = r_ret_cnt;
    case (r_state)
      ST_RUN: begin
        // A mispredicted branch squashes the ret behind it, so it wins
        if (w_mispredict) begin
          w_d_bubble = 1'b1;
          w_e_bubble = 1'b1;
        end else if (w_load_use) begin
          w_f_stall  = 1'b1;
          w_d_stall  = 1'b1;
          w_e_bubble = 1'b1;
        end else if (D_icode == I_RET) begin
          w_f_stall      = 1'b1;
          w_d_bubble     = 1'b1;
          w_next_state   = ST_RET_WAIT;
          w_next_ret_cnt = 2'd2;
        end
      end
      ST_RET_WAIT: begin
        w_f_stall      = 1'b1;
        w_d_bubble     = 1'b1;
        w_next_ret_cnt = r_ret_cnt - 2'd1;
        if (r_ret_cnt == 2'd1)
          w_next_state = ST_RUN;
      end
      ST_HALT: begin
        w_f_stall  = 1'b1;
        w_d_stall  = 1'b1;
        w_w_stall  = 1'b1;
        w_e_bubble = 1'b1;
        w_m_bubble = 1'b1;
      end
      default: begin
        w_next_state   = ST_RUN;
        w_next_ret_cnt = 2'd0;
      end
    endcase
    if ((m_stat != S_AOK) || (W_stat != S_AOK))
      w_m_bubble = 1'b1;
    if (W_stat != S_AOK) begin
      w_w_stall    = 1'b1;
      w_next_state = ST_HALT;
    end
  end

  // State and ret countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_ret_cnt <= 2'd0;
    end else begin
      r_state   <= w_next_state;
      r_ret_cnt <= w_next_ret_cnt;
    end
  end

  assign F_stall  = w_f_stall;
  assign D_stall  = w_d_stall;
  assign W_stall  = w_w_stall;
  assign D_bubble = w_d_bubble & ~w_d_stall;
  assign E_bubble = w_e_bubble;
  assign M_bubble = w_m_bubble;
  assign halted   = (r_state == ST_HALT);
  assign state    = r_state;

  assign w_not_halt = (r_state != ST_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_not_halt),
    .cnt (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_not_halt & w_f_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second 4-bit-counter instance checks saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  D_icode, E_icode, E_dstM, d_srcA, d_srcB;
  logic        e_Cnd;
  logic [1:0]  m_stat, W_stat;
  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, stall_cnt;
  logic        F_stall4, D_stall4, W_stall4, D_bubble4, E_bubble4, M_bubble4, halted4;
  logic [1:0]  state4;
  logic [3:0]  cycle_cnt4, stall_cnt4;

  int n_chk = 0;
  int n_err = 0;
  int exp_cyc = 0;
  bit exp_halt = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .halted(halted), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall4), .D_stall(D_stall4), .W_stall(W_stall4), .D_bubble(D_bubble4),
    .E_bubble(E_bubble4), .M_bubble(M_bubble4), .halted(halted4), .state(state4),
    .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: F_stall D_stall W_stall D_bubble E_bubble M_bubble
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble}, {26'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!exp_halt) exp_cyc++;
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    e_Cnd = 1'b0; m_stat = 2'd0; W_stat = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk_ctl("rst_ctl", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_cycle", cycle_cnt, exp_cyc);

    // ret with no hazards: three fetch-stall cycles
    D_icode = 4'h9;
    #1;
    chk_ctl("ret_c1_ctl", 6'b100100);
    chk("ret_c1_state", {30'd0, state}, 32'd0);
    step();
    D_icode = 4'h1;
    #1;
    chk("ret_c2_state", {30'd0, state}, 32'd1);
    chk_ctl("ret_c2_ctl", 6'b100100);
    step();
    chk("ret_c3_state", {30'd0, state}, 32'd1);
    chk_ctl("ret_c3_ctl", 6'b100100);
    step();
    chk("ret_done_state", {30'd0, state}, 32'd0);
    chk_ctl("ret_done_ctl", 6'b000000);
    chk("ret_stall_cnt", stall_cnt, 32'd3);
    chk("ret_cycle_cnt", cycle_cnt, 32'd4);

    // load-use via srcA, with a ret in decode that must wait
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9;
    #1;
    chk_ctl("lu_srcA_ctl", 6'b110010);
    step();
    chk("lu_state", {30'd0, state}, 32'd0);
    chk("lu_stall_cnt", stall_cnt, 32'd4);
    E_icode = 4'hB; d_srcA = 4'hF; d_srcB = 4'h3; D_icode = 4'h1;
    #1;
    chk_ctl("lu_popq_srcB_ctl", 6'b110010);
    E_dstM = 4'hF; d_srcB = 4'hF;
    #1;
    chk_ctl("lu_none_ctl", 6'b000000);
    E_icode = 4'h5; E_dstM = 4'h4; d_srcA = 4'h3;
    #1;
    chk_ctl("lu_nomatch_ctl", 6'b000000);

    // mispredict beats a ret in decode
    idle();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    #1;
    chk_ctl("mp_ctl", 6'b000110);
    step();
    chk("mp_state", {30'd0, state}, 32'd0);
    chk("mp_stall_cnt", stall_cnt, 32'd4);

    idle();
    m_stat = 2'd2;
    #1;
    chk_ctl("mstat_ctl", 6'b000001);
    m_stat = 2'd0;

    // taken jump does not block the ret; then halt from RET_WAIT
    E_icode = 4'h7; e_Cnd = 1'b1; D_icode = 4'h9;
    #1;
    chk_ctl("jtaken_ret_ctl", 6'b100100);
    step();
    idle();
    W_stat = 2'd1;
    #1;
    chk("rw_state", {30'd0, state}, 32'd1);
    chk_ctl("rw_wstat_ctl", 6'b101101);
    step();
    exp_halt = 1'b1;
    W_stat = 2'd0;
    #1;
    chk("halt_state", {30'd0, state}, 32'd2);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk_ctl("halt_ctl", 6'b111011);
    step();
    step();
    chk("halt_sticky_state", {30'd0, state}, 32'd2);
    chk("halt_cycle_frozen", cycle_cnt, exp_cyc);
    chk("halt_stall_frozen", stall_cnt, 32'd6);

    // asynchronous reset out of HALT
    #2;
    rst = 1'b1;
    #1;
    chk("rsth_state", {30'd0, state}, 32'd0);
    chk("rsth_halted", {31'd0, halted}, 32'd0);
    chk("rsth_cycle", cycle_cnt, 32'd0);
    chk("rsth_stall", stall_cnt, 32'd0);
    chk_ctl("rsth_ctl", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    exp_halt = 1'b0;
    exp_cyc = 0;
    step();
    chk("rsth_post_state", {30'd0, state}, 32'd0);
    chk_ctl("rsth_post_ctl", 6'b000000);

    // asynchronous reset out of RET_WAIT
    D_icode = 4'h9;
    step();
    D_icode = 4'h1;
    #1;
    chk("rw2_state", {30'd0, state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_state", {30'd0, state}, 32'd0);
    chk_ctl("rstw_ctl", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    exp_cyc = 0;
    step();
    chk("rstw_post_state", {30'd0, state}, 32'd0);
    chk_ctl("rstw_post_ctl", 6'b000000);
    chk("rstw_post_stall", stall_cnt, 32'd0);

    // free run: 4-bit counter saturates, 32-bit one keeps counting
    repeat (20) step();
    chk("sat4_cycle", {28'd0, cycle_cnt4}, 32'd15);
    chk("sat4_stall", {28'd0, stall_cnt4}, 32'd0);
    chk("free_cycle32", cycle_cnt, 32'd21);
    chk("free_cycle_model", cycle_cnt, exp_cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of both performance counters.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 D_icode  input  4  icode in decode register.
REQ-005 E_icode  input  4  icode in execute register.
REQ-006 E_dstM  input  4  execute-stage memory destination; 4'hF = none.
REQ-007 d_srcA, d_srcB  input  4 each  decode source registers; 4'hF = none.
REQ-008 e_Cnd  input  1  branch condition computed in execute.
REQ-009 m_stat, W_stat  input  2 each  memory-stage / writeback status.
REQ-010 F_stall, D_stall, W_stall  output  1 each  hold the named pipeline register.
REQ-011 D_bubble, E_bubble, M_bubble  output  1 each  load a nop into the named pipeline register.
REQ-012 halted  output  1  controller in HALT.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 cycle_cnt, stall_cnt  output  CNT_W each  performance counters.

Function
REQ-015 Stall/bubble outputs SHALL be combinational from state and inputs, with zero-cycle latency; state, ret_cnt and counters SHALL be registered.
REQ-016 FSM states SHALL be RUN=0, RET_WAIT=1, HALT=2.
REQ-017 Status encoding SHALL be AOK=0, HLT=1, ADR=2, INS=3.
REQ-018 Load-use SHALL be asserted when E_icode is MRMOVQ(5) or POPQ(B), E_dstM != F, and E_dstM equals d_srcA or d_srcB.
REQ-019 Mispredict SHALL be asserted when E_icode is JXX(7) and e_Cnd = 0.
REQ-020 In RUN with mispredict: D_bubble=1, E_bubble=1, no stalls, and no transition to RET_WAIT even if D_icode is RET.
REQ-021 In RUN with load-use (no mispredict): F_stall=1, D_stall=1, E_bubble=1, and D_bubble=0.
REQ-022 In RUN with D_icode=RET(9) and neither mispredict nor load-use: F_stall=1, D_bubble=1; next state SHALL be RET_WAIT with ret_cnt<=2.
REQ-023 In RET_WAIT: F_stall=1, D_bubble=1; ret_cnt decrements each cycle; when ret_cnt==1 the next state SHALL be RUN; total fetch stall SHALL be exactly 3 cycles per ret.
REQ-024 If m_stat != AOK or W_stat != AOK, M_bubble SHALL be 1 in any state.
REQ-025 If W_stat != AOK, W_stall SHALL be 1 and the next state SHALL be HALT from any state, taking priority over all other transitions.
REQ-026 In HALT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, halted=1; HALT SHALL be left only by rst.
REQ-027 D_stall and D_bubble SHALL never both be 1; D_stall takes priority.
REQ-028 cycle_cnt SHALL increment every cycle not in HALT, saturating at all-ones.
REQ-029 stall_cnt SHALL increment on each non-HALT cycle with F_stall=1, saturating at all-ones.

Reset
REQ-030 On rst, state SHALL be RUN, ret_cnt=0, cycle_cnt=0, stall_cnt=0 and halted=0 immediately and asynchronously; all stall/bubble outputs then follow RUN rules.
REQ-031 Reset asserted during RET_WAIT or HALT SHALL abandon that state with no residual stall on the first post-reset cycle.

Structure
REQ-032 The icode constants (RET, JXX, MRMOVQ, POPQ), the status encodings and the state encoding SHALL live in shared package y86_pkg.
REQ-033 Both counters SHALL be instances of one sub-module, sat_counter, parameterized by CNT_W, with inputs clk, rst and inc.

Verification
REQ-034 D_icode=9, no hazards -> F_stall=1 and D_bubble=1 for exactly 3 cycles, state 0->1->1->0, stall_cnt=3.
REQ-035 E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1 and D_bubble=0 that cycle.
REQ-036 E_icode=7, e_Cnd=0, D_icode=9 simultaneously -> D_bubble=E_bubble=1, F_stall=0, state stays RUN.
REQ-037 W_stat=1 during RET_WAIT -> next cycle state=2, halted=1, cycle_cnt frozen; rst -> state=0, counters 0.
REQ-038 CNT_W=4, 20 free-running cycles -> cycle_cnt saturates at 15.
